if_id_stage: RTL and testbench

- IF/ID pipeline register plus load-use hazard detection and taken-branch flush control.
- Sits between instruction fetch and the ID/EX buffer, feeding it decoded register indices and funct fields.
- Drives PC write-enable and the bubble select that zeroes ID/EX control inputs.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/if_id_stage.sv | 81 ++++++++
 tb/tb_if_id_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load-use stall and taken-branch flush control
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR   = 32'h00000013,
    parameter int          FLUSH_DEPTH = 1,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      PC_In,
    input  logic [31:0]      Instr_In,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rd,
    input  logic             BranchTaken,
    output logic [63:0]      PC_Out,
    output logic [31:0]      Instr_Out,
    output logic [4:0]       Rs1,
    output logic [4:0]       Rs2,
    output logic [4:0]       Rd,
    output logic [2:0]       funct3,
    output logic [3:0]       Funct,
    output logic             Valid,
    output logic             PCWrite,
    output logic             Bubble,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t     state;
    logic [1:0] fc;
    logic       uses_rs2;
    logic       hz;
    logic       stall;

    assign Rs1    = Instr_Out[19:15];
    assign Rs2    = Instr_Out[24:20];
    assign Rd     = Instr_Out[11:7];
    assign funct3 = Instr_Out[14:12];
    assign Funct  = {Instr_Out[30], Instr_Out[14:12]};

    // Load-use detection against the ID/EX load; flush beats stall, FLUSH state ignores hazards
    always_comb begin
        uses_rs2 = (Instr_Out[6:0] == 7'b0110011) || (Instr_Out[6:0] == 7'b0100011) || (Instr_Out[6:0] == 7'b1100011);
        hz       = Valid & IDEX_MemRead & (IDEX_Rd != 5'd0) & ((IDEX_Rd == Rs1) | (uses_rs2 & (IDEX_Rd == Rs2)));
        stall    = (state == RUN) & hz & ~BranchTaken;
        PCWrite  = ~stall;
        Bubble   = stall | BranchTaken | (state == FLUSH);
    end

    // Pipeline register, flush sequencer and saturating debug counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_Out     <= '0;
            Instr_Out  <= NOP_INSTR;
            Valid      <= 1'b0;
            state      <= RUN;
            fc         <= '0;
            StallCount <= '0;
            FlushCount <= '0;
        end else if (BranchTaken) begin
            PC_Out     <= PC_In;
            Instr_Out  <= NOP_INSTR;
            Valid      <= 1'b0;
            FlushCount <= (&FlushCount) ? FlushCount : FlushCount + CNT_W'(1);
            state      <= (FLUSH_DEPTH > 1) ? FLUSH : RUN;
            fc         <= 2'(FLUSH_DEPTH - 1);
        end else if (state == FLUSH) begin
            PC_Out     <= PC_In;
            Instr_Out  <= NOP_INSTR;
            Valid      <= 1'b0;
            fc         <= fc - 2'd1;
            state      <= (fc == 2'd1) ? RUN : FLUSH;
        end else if (hz) begin
            StallCount <= (&StallCount) ? StallCount : StallCount + CNT_W'(1);
        end else begin
            PC_Out     <= PC_In;
            Instr_Out  <= Instr_In;
            Valid      <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: table-driven check of IF/ID register, stall, flush and counter saturation
module tb_if_id_stage;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ADD10 = 32'h00B50533;
    localparam logic [31:0] ADD12 = 32'h00628633;
    localparam logic [31:0] ADDI  = 32'h00628393;
    localparam logic [31:0] SUB   = 32'h403100B3;
    localparam logic [31:0] SW    = 32'h0062A023;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic        memrd = 1'b0;
    logic [4:0]  idex_rd = '0;
    logic        bt = 1'b0;

    logic [63:0] pc_o, pc_o1;
    logic [31:0] ins_o, ins_o1;
    logic [4:0]  rs1, rs2, rd, rs1_1, rs2_1, rd_1;
    logic [2:0]  f3, f3_1;
    logic [3:0]  fn, fn_1;
    logic        v, v1, pw, pw1, bub, bub1;
    logic [1:0]  sc, fcn;
    logic [15:0] sc1, fcn1;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_id_stage #(.FLUSH_DEPTH(2), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .PC_In(pc_in), .Instr_In(instr_in),
        .IDEX_MemRead(memrd), .IDEX_Rd(idex_rd), .BranchTaken(bt),
        .PC_Out(pc_o), .Instr_Out(ins_o), .Rs1(rs1), .Rs2(rs2), .Rd(rd),
        .funct3(f3), .Funct(fn), .Valid(v), .PCWrite(pw), .Bubble(bub),
        .StallCount(sc), .FlushCount(fcn)
    );

    if_id_stage d1 (
        .clk(clk), .reset(reset), .PC_In(pc_in), .Instr_In(instr_in),
        .IDEX_MemRead(memrd), .IDEX_Rd(idex_rd), .BranchTaken(bt),
        .PC_Out(pc_o1), .Instr_Out(ins_o1), .Rs1(rs1_1), .Rs2(rs2_1), .Rd(rd_1),
        .funct3(f3_1), .Funct(fn_1), .Valid(v1), .PCWrite(pw1), .Bubble(bub1),
        .StallCount(sc1), .FlushCount(fcn1)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mr;
        logic [4:0]  xrd;
        logic        br;
        logic        e_pw;
        logic        e_bub;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        logic        e_v;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rs2;
        logic [4:0]  e_rd;
        logic [3:0]  e_fn;
        logic [1:0]  e_sc;
        logic [1:0]  e_fc;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{64'h100, ADD10, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 64'h100, ADD10, 1'b1, 5'd10, 5'd11, 5'd10, 4'h0, 2'd0, 2'd0};
        tbl[1]  = '{64'h104, ADD12, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 64'h104, ADD12, 1'b1, 5'd5,  5'd6,  5'd12, 4'h0, 2'd0, 2'd0};
        tbl[2]  = '{64'h108, ADDI,  1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 64'h104, ADD12, 1'b1, 5'd5,  5'd6,  5'd12, 4'h0, 2'd1, 2'd0};
        tbl[3]  = '{64'h108, ADDI,  1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 64'h108, ADDI,  1'b1, 5'd5,  5'd6,  5'd7,  4'h0, 2'd1, 2'd0};
        tbl[4]  = '{64'h10C, SUB,   1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 64'h10C, SUB,   1'b1, 5'd2,  5'd3,  5'd1,  4'h8, 2'd1, 2'd0};
        tbl[5]  = '{64'h110, SW,    1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 64'h10C, SUB,   1'b1, 5'd2,  5'd3,  5'd1,  4'h8, 2'd2, 2'd0};
        tbl[6]  = '{64'h110, SW,    1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 64'h110, SW,    1'b1, 5'd5,  5'd6,  5'd0,  4'h2, 2'd2, 2'd0};
        tbl[7]  = '{64'h114, ADD10, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 64'h110, SW,    1'b1, 5'd5,  5'd6,  5'd0,  4'h2, 2'd3, 2'd0};
        tbl[8]  = '{64'h114, ADD10, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 64'h110, SW,    1'b1, 5'd5,  5'd6,  5'd0,  4'h2, 2'd3, 2'd0};
        tbl[9]  = '{64'h114, ADD10, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 64'h110, SW,    1'b1, 5'd5,  5'd6,  5'd0,  4'h2, 2'd3, 2'd0};
        tbl[10] = '{64'h200, ADD10, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 64'h200, NOP,   1'b0, 5'd0,  5'd0,  5'd0,  4'h0, 2'd3, 2'd1};
        tbl[11] = '{64'h204, ADD10, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1, 64'h204, NOP,   1'b0, 5'd0,  5'd0,  5'd0,  4'h0, 2'd3, 2'd1};
        tbl[12] = '{64'h208, ADD10, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 64'h208, ADD10, 1'b1, 5'd10, 5'd11, 5'd10, 4'h0, 2'd3, 2'd1};
        tbl[13] = '{64'h300, ADD12, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 64'h300, NOP,   1'b0, 5'd0,  5'd0,  5'd0,  4'h0, 2'd3, 2'd2};
        tbl[14] = '{64'h304, ADD12, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 64'h304, NOP,   1'b0, 5'd0,  5'd0,  5'd0,  4'h0, 2'd3, 2'd3};
        tbl[15] = '{64'h308, ADD12, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 64'h308, NOP,   1'b0, 5'd0,  5'd0,  5'd0,  4'h0, 2'd3, 2'd3};
        tbl[16] = '{64'h30C, ADD12, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 64'h30C, NOP,   1'b0, 5'd0,  5'd0,  5'd0,  4'h0, 2'd3, 2'd3};
        tbl[17] = '{64'h310, ADD12, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 64'h310, ADD12, 1'b1, 5'd5,  5'd6,  5'd12, 4'h0, 2'd3, 2'd3};

        tick();
        tick();
        chk("rst pc", pc_o, 64'h0);
        chk("rst instr", 64'(ins_o), 64'(NOP));
        chk("rst valid", 64'(v), 64'd0);
        chk("rst fields", 64'({rs1, rs2, rd, f3, fn}), 64'd0);
        chk("rst counts", 64'({sc, fcn}), 64'd0);
        chk("rst pcwrite/bubble", 64'({pw, bub}), 64'b10);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            pc_in    = tbl[i].pc;
            instr_in = tbl[i].instr;
            memrd    = tbl[i].mr;
            idex_rd  = tbl[i].xrd;
            bt       = tbl[i].br;
            #1;
            chk($sformatf("v%0d pcwrite", i), 64'(pw), 64'(tbl[i].e_pw));
            chk($sformatf("v%0d bubble", i), 64'(bub), 64'(tbl[i].e_bub));
            tick();
            chk($sformatf("v%0d pc_out", i), pc_o, tbl[i].e_pc);
            chk($sformatf("v%0d instr_out", i), 64'(ins_o), 64'(tbl[i].e_ins));
            chk($sformatf("v%0d valid", i), 64'(v), 64'(tbl[i].e_v));
            chk($sformatf("v%0d rs1/rs2/rd", i), 64'({rs1, rs2, rd}), 64'({tbl[i].e_rs1, tbl[i].e_rs2, tbl[i].e_rd}));
            chk($sformatf("v%0d funct/funct3", i), 64'({fn, f3}), 64'({tbl[i].e_fn, tbl[i].e_fn[2:0]}));
            chk($sformatf("v%0d stallcount", i), 64'(sc), 64'(tbl[i].e_sc));
            chk($sformatf("v%0d flushcount", i), 64'(fcn), 64'(tbl[i].e_fc));
        end

        chk("d1 stallcount wide", 64'(sc1), 64'd5);
        chk("d1 flushcount wide", 64'(fcn1), 64'd4);

        pc_in = 64'h400; instr_in = ADD10; memrd = 1'b0; idex_rd = 5'd0; bt = 1'b0;
        tick();
        chk("d1 load valid", 64'(v1), 64'd1);
        bt = 1'b1; pc_in = 64'h404;
        #1;
        chk("d1 br bubble/pcwrite", 64'({bub1, pw1}), 64'b11);
        tick();
        chk("d1 br instr", 64'(ins_o1), 64'(NOP));
        chk("d1 br valid", 64'(v1), 64'd0);
        chk("d1 br pc", pc_o1, 64'h404);
        bt = 1'b0; pc_in = 64'h408; instr_in = ADD12;
        #1;
        chk("depth2 flush bubble", 64'(bub), 64'd1);
        chk("depth1 run bubble", 64'(bub1), 64'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("rst abandons flush bubble", 64'(bub), 64'd0);
        chk("rst abandons flush pcwrite", 64'(pw), 64'd1);
        chk("rst mid flushcount", 64'(fcn), 64'd0);
        #1;
        reset = 1'b0;
        tick();
        chk("post-rst load instr", 64'(ins_o), 64'(ADD12));
        chk("post-rst load valid", 64'(v), 64'd1);

        tbl[0].e_sc = sc;
        memrd = 1'b1; idex_rd = 5'd5; pc_in = 64'h40C;
        tick();
        chk("pre-rst stall pcwrite", 64'(pw), 64'd0);
        chk("pre-rst stall count", 64'(sc), 64'(tbl[0].e_sc + 2'd1));
        #2;
        reset = 1'b1;
        #1;
        chk("async rst pc", pc_o, 64'h0);
        chk("async rst instr", 64'(ins_o), 64'(NOP));
        chk("async rst valid", 64'(v), 64'd0);
        chk("async rst fields", 64'({rs1, rs2, rd, fn}), 64'd0);
        chk("async rst counts", 64'({sc, fcn, sc1, fcn1}), 64'd0);
        chk("async rst pcwrite", 64'(pw), 64'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
